shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one 32-bit barrel shifter (logical left, logical right, arithmetic right) between NUM_REQ requesters. Each requester presents an operand, shift amount and opcode on a valid/ready port. A round-robin arbiter grants one request per cycle and registers the result into a one-entry response buffer, tagged with the requester index. The block sits between the execution front-ends and the shared shift datapath.

## Interface
- NUM_REQ, default 4: number of requester ports, 2..8.
- ID_W, default 2: width of the response tag. Must be at least clog2(NUM_REQ).
- clk  input  1: clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- req_valid  input  NUM_REQ: per-requester request valid.
- req_ready  output  NUM_REQ: per-requester accept; one-hot or zero.
- req_in  input  NUM_REQ*32: operands; requester i occupies bits [32i+31:32i].
- req_amt  input  NUM_REQ*5: shift amounts, 0..31; requester i occupies bits [5i+4:5i].
- req_op  input  NUM_REQ*2: opcode per requester. 00 = lsl, 01 = lsr, 10 = asr, 11 = illegal.
- rsp_valid  output  1: response buffer holds a result.
- rsp_ready  input  1: consumer accepts the response.
- rsp_data  output  32: shifted result.
- rsp_id  output  ID_W: index of the requester that produced the result.
- rsp_err  output  1: the request carried illegal opcode 11.

## Operation
- State is a one-entry response buffer (full/empty) plus a round-robin pointer `ptr` (0..NUM_REQ-1).
- Buffer availability: `can_accept = !rsp_valid || rsp_ready`. This gives bubble-free streaming, with one accept per cycle under continuous back-pressure release.
- Arbitration:
  - When can_accept is set, grant the first i with req_valid[i], searching i = ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[i] = 1 only for the granted i. All zero when nothing is granted or can_accept = 0.
  - req_ready depends combinationally on req_valid and rsp_ready; there is no other combinational input-to-output path.
- On a grant (req_valid[g] && req_ready[g]):
  - rsp_data <= shift(req_in[g], req_amt[g], req_op[g]).
  - rsp_id <= g.
  - rsp_err <= (req_op[g] == 11).
  - rsp_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
- On a response pop with no grant in the same cycle: rsp_valid <= 0. rsp_data, rsp_id and rsp_err hold their values.
- Shift semantics:
  - lsl: in << amt, zero fill, truncated to 32 bits.
  - lsr: in >> amt, zero fill.
  - asr: signed in >>> amt, filled with in[31].
  - amt = 0 returns in unchanged for every legal op.
  - Illegal op returns in unchanged and sets rsp_err.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepted transactions.
- ptr advances only on a grant. Idle cycles and stalled cycles leave it unchanged.
- Requesters must hold req_valid and their payload stable until accepted. The block does not check this.

## Timing
- Reset values (rst high at a clock edge): rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, ptr = 0. req_ready = 0 for the whole cycle rst is high.
- Latency: a request accepted at edge N is visible on rsp_* immediately after edge N (one cycle from request to response).
- Throughput: 1 result per cycle while rsp_ready = 1.
- Full buffer with rsp_ready = 0: all req_ready = 0, rsp_* held stable, ptr frozen.
- Simultaneous pop and grant in one cycle: the new result replaces the old one, rsp_valid stays 1, and the response is neither lost nor duplicated.
- Wrap-around: ptr = NUM_REQ-1 with grant g = NUM_REQ-1 gives ptr = 0.
- Reset mid-operation: any buffered response is discarded and no grant is issued that cycle. The first grant after reset searches from index 0.

## Test plan
- Single-requester ops: req 0, in = A5A5A5A5, amt = 2:
  - op 00 -> rsp_data 96969694.
  - op 01 -> rsp_data 29696969.
  - op 10 -> rsp_data E9696969.
  - Each has rsp_id 0, rsp_err 0, and rsp_valid one cycle after accept.
- Boundary amounts and illegal op:
  - in = 80000000, amt = 31: asr -> FFFFFFFF; lsr -> 00000001.
  - amt = 0 -> 80000000 for all ops.
  - op 11 -> 80000000 with rsp_err 1.
- Round-robin: all 4 requesters valid continuously, rsp_ready = 1 -> rsp_id sequence 0,1,2,3,0,1 and one result every cycle.
- Back-pressure: hold rsp_ready = 0 for 5 cycles with a full buffer -> req_ready all 0 and rsp_* stable. Release -> the next grant is in the same cycle as the pop, rsp_valid stays continuously 1.
- Fairness: requester 1 held valid while requesters 0 and 2 re-request every cycle -> requester 1 is granted within 4 accepts. Each accepted request produces exactly one response, checked by a scoreboard.
- Reset mid-stream: assert rst while rsp_valid = 1 and ptr = 2 -> rsp_valid = 0 next cycle. After release, with requesters 0 and 3 valid, the first grant goes to 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one 32-bit barrel shifter (lsl / lsr / asr) between NUM_REQ
//   requesters. A round-robin arbiter grants at most one request per cycle;
//   the shifted result is registered into a one-entry response buffer,
//   tagged with the index of the requester that produced it.
//
// Parameters
//   NUM_REQ : number of requester ports (2..8)
//   ID_W    : width of the response tag, at least clog2(NUM_REQ)
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_in     : packed 32-bit operands, requester i at [32i+31:32i]
//   req_amt    : packed 5-bit shift amounts, requester i at [5i+4:5i]
//   req_op     : packed 2-bit opcodes (00 lsl, 01 lsr, 10 asr, 11 illegal)
//   rsp_valid  : response buffer holds a result
//   rsp_ready  : consumer accepts the response
//   rsp_data   : shifted result
//   rsp_id     : index of the requester that produced the result
//   rsp_err    : the request carried the illegal opcode
module shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_in,
  input  logic [NUM_REQ*5-1:0]   req_amt,
  input  logic [NUM_REQ*2-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err
);

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  function automatic logic [DATA_W-1:0] shift_op(
    input logic [DATA_W-1:0] din,
    input logic [AMT_W-1:0]  amt,
    input logic [1:0]        op
  );
    logic signed [DATA_W-1:0] sdin;
    sdin = din;
    case (op)
      2'b00:   shift_op = din << amt;
      2'b01:   shift_op = din >> amt;
      2'b10:   shift_op = $unsigned(sdin >>> amt);
      default: shift_op = din;
    endcase
  endfunction

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ID_W-1:0]   ptr_q,       ptr_d;

  logic              can_accept;
  logic              gnt_found;
  logic              gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] sel_in;
  logic [AMT_W-1:0]  sel_amt;
  logic [1:0]        sel_op;

  // ---- arbitration: first valid requester at or after ptr, modulo NUM_REQ
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  // A pop in the same cycle frees the buffer, so streaming stays bubble-free.
  // Reset suppresses any grant so nothing is accepted and then discarded.
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign gnt        = gnt_found && can_accept && !rst;
  assign req_ready  = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign sel_in  = req_in[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_amt = req_amt[int'(gnt_idx)*AMT_W +: AMT_W];
  assign sel_op  = req_op[int'(gnt_idx)*2 +: 2];

  // ---- shift and response-buffer update
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    ptr_d       = ptr_q;
    if (gnt) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = shift_op(sel_in, sel_amt, sel_op);
      rsp_id_d    = gnt_idx;
      rsp_err_d   = (sel_op == 2'b11);
      ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // ---- registered response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
//   Directed-vector bench for shift_arbiter with NUM_REQ = 4: a table of
//   single-requester shift vectors, then hand-written sequences for
//   round-robin order, back-pressure, reset mid-stream and fairness with a
//   response scoreboard.
module tb_shift_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*32-1:0]  req_in;
  logic [N*5-1:0]   req_amt;
  logic [N*2-1:0]   req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_err;

  shift_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0]     d;
    logic [ID_W-1:0] id;
    logic            e;
  } rsp_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [31:0] d, input logic [4:0] a,
                          input logic [1:0] o);
    req_in[i*32 +: 32] = d;
    req_amt[i*5 +: 5]  = a;
    req_op[i*2 +: 2]   = o;
  endtask

  // Reference shift written independently of the DUT formulation.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                            input logic [1:0] o);
    logic [31:0] fill;
    fill = d[31] ? ~(32'hFFFF_FFFF >> a) : 32'h0;
    case (o)
      2'd0:    ref_shift = d << a;
      2'd1:    ref_shift = d >> a;
      2'd2:    ref_shift = (d >> a) | fill;
      default: ref_shift = d;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[14];
  rsp_t sb[$];

  initial begin
    logic [31:0]     held_data;
    logic [ID_W-1:0] held_id;
    logic            held_err;
    logic [N-1:0]    acc_last;
    int              wait1, gap1, n_acc, n_rsp;
    rsp_t            r;

    vecs[0]  = '{32'hA5A5A5A5, 5'd2,  2'b00, 32'h96969694, 1'b0};
    vecs[1]  = '{32'hA5A5A5A5, 5'd2,  2'b01, 32'h29696969, 1'b0};
    vecs[2]  = '{32'hA5A5A5A5, 5'd2,  2'b10, 32'hE9696969, 1'b0};
    vecs[3]  = '{32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'h80000000, 5'd31, 2'b01, 32'h00000001, 1'b0};
    vecs[5]  = '{32'h80000000, 5'd0,  2'b00, 32'h80000000, 1'b0};
    vecs[6]  = '{32'h80000000, 5'd0,  2'b01, 32'h80000000, 1'b0};
    vecs[7]  = '{32'h80000000, 5'd0,  2'b10, 32'h80000000, 1'b0};
    vecs[8]  = '{32'h80000000, 5'd0,  2'b11, 32'h80000000, 1'b1};
    vecs[9]  = '{32'h80000000, 5'd31, 2'b00, 32'h00000000, 1'b0};
    vecs[10] = '{32'h12345678, 5'd7,  2'b11, 32'h12345678, 1'b1};
    vecs[11] = '{32'h7FFFFFFF, 5'd4,  2'b10, 32'h07FFFFFF, 1'b0};
    vecs[12] = '{32'h00000001, 5'd31, 2'b00, 32'h80000000, 1'b0};
    vecs[13] = '{32'hF0000000, 5'd4,  2'b01, 32'h0F000000, 1'b0};

    // Reset state, with every requester asking during reset.
    rst       = 1'b1;
    req_valid = '1;
    req_in    = {N{32'hDEADBEEF}};
    req_amt   = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data",  rsp_data,       32'h0);
    chk("rst_id",    32'(rsp_id),    32'h0);
    chk("rst_err",   32'(rsp_err),   32'h0);
    rst       = 1'b0;
    req_valid = '0;

    // Table of single-requester vectors on port 0.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      set_port(0, vecs[k].din, vecs[k].amt, vecs[k].op);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'h1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("vec%0d_data", k),  rsp_data,       vecs[k].exp);
      chk($sformatf("vec%0d_id", k),    32'(rsp_id),    32'h0);
      chk($sformatf("vec%0d_err", k),   32'(rsp_err),   32'(vecs[k].err));
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_pop", k),   32'(rsp_valid), 32'h0);
      chk($sformatf("vec%0d_hold", k),  rsp_data,       vecs[k].exp);
    end

    // Round-robin: all requesters valid, consumer always ready.
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 32'h11111111 * (i + 1), 5'(i), 2'b00);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(1 << (i % N)));
      @(negedge clk);
      chk($sformatf("rr%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("rr%0d_id", i),    32'(rsp_id),    32'(i % N));
      chk($sformatf("rr%0d_data", i),  rsp_data,
          (32'h11111111 * ((i % N) + 1)) << (i % N));
    end

    // Back-pressure: full buffer, consumer stalls for 5 cycles.
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    held_err  = rsp_err;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d_data", i),  rsp_data,       held_data);
      chk($sformatf("bp%0d_id", i),    32'(rsp_id),    32'(held_id));
      chk($sformatf("bp%0d_err", i),   32'(rsp_err),   32'(held_err));
    end
    // Release: pointer still at 2, grant coincides with the pop.
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    chk("rel_valid", 32'(rsp_valid), 32'h1);
    chk("rel_id",    32'(rsp_id),    32'h2);

    // Get ptr to 2 with a buffered response, then reset mid-stream.
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    chk("pre_rst_id",    32'(rsp_id),    32'h1);
    rst       = 1'b1;
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_data",  rsp_data,       32'h0);
    chk("mid_rst_id",    32'(rsp_id),    32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_id",    32'(rsp_id),    32'h0);
    chk("post_rst_data",  rsp_data,       32'h11111111);

    // Fairness with random consumer stalls and a response scoreboard.
    do_reset();
    acc_last = '0;
    wait1    = 0;
    gap1     = 0;
    n_acc    = 0;
    n_rsp    = 0;
    for (int c = 0; c < 80; c++) begin
      if (c != 0) @(negedge clk);
      for (int i = 0; i < N; i += 2) begin
        if (acc_last[i] || !req_valid[i]) begin
          set_port(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
          req_valid[i] = 1'b1;
        end
      end
      req_valid[3] = 1'b0;
      if (acc_last[1]) begin
        req_valid[1] = 1'b0;
        gap1 = $urandom_range(0, 2);
      end else if (!req_valid[1]) begin
        if (gap1 == 0) begin
          set_port(1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
          req_valid[1] = 1'b1;
          wait1 = 0;
        end else begin
          gap1--;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          r = sb.pop_front();
          chk("sb_data", rsp_data,     r.d);
          chk("sb_id",   32'(rsp_id),  32'(r.id));
          chk("sb_err",  32'(rsp_err), 32'(r.e));
        end
      end
      chk("fair_onehot", 32'($onehot0(req_ready)), 32'h1);
      acc_last = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc_last[i]) begin
          n_acc++;
          r.d  = ref_shift(req_in[i*32 +: 32], req_amt[i*5 +: 5], req_op[i*2 +: 2]);
          r.id = ID_W'(i);
          r.e  = (req_op[i*2 +: 2] == 2'b11);
          sb.push_back(r);
        end
      end
      if (acc_last[1]) chk("fair_wait", 32'(wait1 < N), 32'h1);
      else if (req_valid[1] && acc_last != '0) wait1++;
    end
    chk("fair_no_starve", 32'(wait1 < N), 32'h1);

    // Drain the buffer and confirm one response per accept.
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rsp_valid) begin
        n_rsp++;
        if (sb.size() == 0) begin
          chk("drain_unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          r = sb.pop_front();
          chk("drain_data", rsp_data,    r.d);
          chk("drain_id",   32'(rsp_id), 32'(r.id));
        end
      end
      @(negedge clk);
    end
    chk("sb_empty",      32'(sb.size()), 32'h0);
    chk("sb_rsp_count",  32'(n_rsp),     32'(n_acc));
    chk("drain_valid",   32'(rsp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
